// File: rtl/noc_pkg.sv
// Shared NoC definitions for the router input-buffer bank.
//   DATASIZE_DEF     default flit width in bits
//   PORT_N..PORT_L   port index of each router input on the flattened buses
//   flit_t           one flit at the default width
package noc_pkg;

    localparam int DATASIZE_DEF = 40;

    localparam int PORT_N = 0;
    localparam int PORT_E = 1;
    localparam int PORT_S = 2;
    localparam int PORT_W = 3;
    localparam int PORT_L = 4;

    typedef logic [DATASIZE_DEF-1:0] flit_t;

endpackage

// File: rtl/noc_fifo_bank_if.sv
// Handshake and status bundle of the router input-buffer bank.
// Port p of every bus sits at slice p.
//   master : link/arbiter side; drives data_in, valid_in, ready_in, err_clr
//   slave  : buffer bank; drives data_out, valid_out, full_out, afull_out,
//            pressure_out, peak_pressure, ovf_err, udf_err
interface noc_fifo_bank_if #(
    parameter int NPORTS   = 5,
    parameter int WIDTH    = 3,
    parameter int DATASIZE = 40
);
    logic [NPORTS*DATASIZE-1:0]  data_in;
    logic [NPORTS-1:0]           valid_in;
    logic [NPORTS-1:0]           ready_in;
    logic                        err_clr;
    logic [NPORTS*DATASIZE-1:0]  data_out;
    logic [NPORTS-1:0]           valid_out;
    logic [NPORTS-1:0]           full_out;
    logic [NPORTS-1:0]           afull_out;
    logic [NPORTS*(WIDTH+1)-1:0] pressure_out;
    logic [WIDTH:0]              peak_pressure;
    logic [NPORTS-1:0]           ovf_err;
    logic [NPORTS-1:0]           udf_err;

    modport master (
        output data_in, valid_in, ready_in, err_clr,
        input  data_out, valid_out, full_out, afull_out, pressure_out,
               peak_pressure, ovf_err, udf_err
    );

    modport slave (
        input  data_in, valid_in, ready_in, err_clr,
        output data_out, valid_out, full_out, afull_out, pressure_out,
               peak_pressure, ovf_err, udf_err
    );
endinterface

// File: rtl/noc_fifo_chan.sv
// One first-word-fall-through FIFO channel of the input-buffer bank.
//   clk, rst_n    clock, async active-low reset
//   wr_data       flit to write; valid_in write request
//   ready_in      pop request
//   err_clr       clears the sticky error flags
//   data_out      head flit (0 while empty); valid_out non-empty
//   full_out      count == DEPTH; afull_out count >= AF_THRESH
//   count         registered occupancy 0..DEPTH
//   ovf_err       sticky: a write was dropped
//   udf_err       sticky: pop requested while empty
module noc_fifo_chan #(
    parameter int DEPTH     = 8,
    parameter int WIDTH     = 3,
    parameter int DATASIZE  = 40,
    parameter int AF_THRESH = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DATASIZE-1:0] wr_data,
    input  logic                valid_in,
    input  logic                ready_in,
    input  logic                err_clr,
    output logic [DATASIZE-1:0] data_out,
    output logic                valid_out,
    output logic                full_out,
    output logic                afull_out,
    output logic [WIDTH:0]      count,
    output logic                ovf_err,
    output logic                udf_err
);
    localparam logic [WIDTH:0] DEPTH_C = (WIDTH+1)'(DEPTH);
    localparam logic [WIDTH:0] AF_C    = (WIDTH+1)'(AF_THRESH);

    logic [DATASIZE-1:0] mem [DEPTH];
    logic [WIDTH-1:0]    rd_ptr;
    logic [WIDTH-1:0]    wr_ptr;
    logic                rd_fire;
    logic                wr_fire;
    logic                ovf_ev;
    logic                udf_ev;

    assign valid_out = (count != '0);
    assign full_out  = (count == DEPTH_C);
    assign afull_out = (count >= AF_C);

    // A full FIFO still accepts a write when the head pops in the same cycle:
    // wr_ptr == rd_ptr then, and the write lands in the slot being freed.
    assign rd_fire = ready_in & valid_out;
    assign wr_fire = valid_in & (~full_out | rd_fire);
    assign ovf_ev  = valid_in & full_out & ~rd_fire;
    assign udf_ev  = ready_in & ~valid_out;

    // No bypass: a flit written into an empty FIFO shows up the next cycle.
    assign data_out = valid_out ? mem[rd_ptr] : '0;

    // Storage carries no reset; data_out is masked by valid_out instead.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            ovf_err <= 1'b0;
            udf_err <= 1'b0;
        end else begin
            // DEPTH == 2**WIDTH, so pointers wrap by plain overflow.
            if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
            if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_fire, rd_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A new error outranks a clear in the same cycle.
            if (ovf_ev)       ovf_err <= 1'b1;
            else if (err_clr) ovf_err <= 1'b0;
            if (udf_ev)       udf_err <= 1'b1;
            else if (err_clr) udf_err <= 1'b0;
        end
    end
endmodule

// File: rtl/noc_fifo_bank.sv
// Router input-buffer bank: NPORTS independent FIFO channels, one per router
// input port, between the link inputs and the arbiter/crossbar.
//   fifo_clk   clock
//   rst_n      async active-low reset
//   bus        noc_fifo_bank_if slave: per-port write/pop handshakes, head
//              flits, fill flags, occupancy, sticky errors, and the
//              registered bank-wide peak occupancy
module noc_fifo_bank import noc_pkg::*; #(
    parameter int NPORTS    = 5,
    parameter int DEPTH     = 8,
    parameter int WIDTH     = 3,
    parameter int DATASIZE  = DATASIZE_DEF,
    parameter int AF_THRESH = 6
) (
    input  logic           fifo_clk,
    input  logic           rst_n,
    noc_fifo_bank_if.slave bus
);
    logic [WIDTH:0] cnt [NPORTS];
    logic [WIDTH:0] peak_next;
    logic [WIDTH:0] peak_q;

    for (genvar p = 0; p < NPORTS; p++) begin : g_chan
        noc_fifo_chan #(
            .DEPTH    (DEPTH),
            .WIDTH    (WIDTH),
            .DATASIZE (DATASIZE),
            .AF_THRESH(AF_THRESH)
        ) u_chan (
            .clk      (fifo_clk),
            .rst_n    (rst_n),
            .wr_data  (bus.data_in[p*DATASIZE +: DATASIZE]),
            .valid_in (bus.valid_in[p]),
            .ready_in (bus.ready_in[p]),
            .err_clr  (bus.err_clr),
            .data_out (bus.data_out[p*DATASIZE +: DATASIZE]),
            .valid_out(bus.valid_out[p]),
            .full_out (bus.full_out[p]),
            .afull_out(bus.afull_out[p]),
            .count    (cnt[p]),
            .ovf_err  (bus.ovf_err[p]),
            .udf_err  (bus.udf_err[p])
        );
        assign bus.pressure_out[p*(WIDTH+1) +: WIDTH+1] = cnt[p];
    end

    // Max over the pre-update counts; the register reports it one cycle later.
    always_comb begin
        peak_next = '0;
        for (int p = 0; p < NPORTS; p++) begin
            if (cnt[p] > peak_next) peak_next = cnt[p];
        end
    end

    always_ff @(posedge fifo_clk or negedge rst_n) begin
        if (!rst_n) peak_q <= '0;
        else        peak_q <= peak_next;
    end

    assign bus.peak_pressure = peak_q;
endmodule

// File: tb/tb_noc_fifo_bank.sv
module tb_noc_fifo_bank;
    import noc_pkg::*;

    localparam int NP    = 5;
    localparam int DEPTH = 8;
    localparam int WIDTH = 3;
    localparam int DW    = DATASIZE_DEF;
    localparam int AF    = 6;

    logic fifo_clk = 1'b0;
    logic rst_n    = 1'b0;
    always #5 fifo_clk = ~fifo_clk;

    noc_fifo_bank_if #(.NPORTS(NP), .WIDTH(WIDTH), .DATASIZE(DW)) bus();

    noc_fifo_bank #(
        .NPORTS(NP), .DEPTH(DEPTH), .WIDTH(WIDTH), .DATASIZE(DW), .AF_THRESH(AF)
    ) dut (
        .fifo_clk(fifo_clk),
        .rst_n   (rst_n),
        .bus     (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Stimulus for the next cycle
    logic [NP-1:0] vin_s;
    logic [NP-1:0] rdy_s;
    logic          clr_s;
    flit_t         din_s [NP];

    // Reference model: one queue per port, sticky flags, peak
    flit_t         mq [NP][$];
    logic [NP-1:0] m_ovf;
    logic [NP-1:0] m_udf;
    int            m_peak;

    typedef struct {
        logic       vin;
        logic       rdy;
        logic [7:0] din;
        logic [3:0] cnt;
        logic       af;
        logic       full;
        logic       valid;
        logic [7:0] head;
    } vec_t;
    vec_t tbl [16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic flit_t head(input int p);
        return bus.data_out[p*DW +: DW];
    endfunction

    function automatic logic [WIDTH:0] pres(input int p);
        return bus.pressure_out[p*(WIDTH+1) +: WIDTH+1];
    endfunction

    task automatic model_reset();
        for (int p = 0; p < NP; p++) mq[p].delete();
        m_ovf  = '0;
        m_udf  = '0;
        m_peak = 0;
    endtask

    task automatic model_step();
        int pk;
        int n;
        bit pop, push, ovf, udf;
        pk = 0;
        for (int p = 0; p < NP; p++) if (mq[p].size() > pk) pk = mq[p].size();
        for (int p = 0; p < NP; p++) begin
            n    = mq[p].size();
            pop  = rdy_s[p] && (n > 0);
            push = vin_s[p] && ((n < DEPTH) || pop);
            ovf  = vin_s[p] && (n == DEPTH) && !pop;
            udf  = rdy_s[p] && (n == 0);
            if (pop)  void'(mq[p].pop_front());
            if (push) mq[p].push_back(din_s[p]);
            m_ovf[p] = ovf ? 1'b1 : (clr_s ? 1'b0 : m_ovf[p]);
            m_udf[p] = udf ? 1'b1 : (clr_s ? 1'b0 : m_udf[p]);
        end
        m_peak = pk;
    endtask

    task automatic check_all();
        int n;
        for (int p = 0; p < NP; p++) begin
            n = mq[p].size();
            chk($sformatf("p%0d valid", p), 64'(bus.valid_out[p]), 64'(n > 0));
            chk($sformatf("p%0d full", p),  64'(bus.full_out[p]),  64'(n == DEPTH));
            chk($sformatf("p%0d afull", p), 64'(bus.afull_out[p]), 64'(n >= AF));
            chk($sformatf("p%0d pressure", p), 64'(pres(p)), 64'(n));
            chk($sformatf("p%0d data", p), 64'(head(p)), (n > 0) ? 64'(mq[p][0]) : 64'd0);
            chk($sformatf("p%0d ovf", p), 64'(bus.ovf_err[p]), 64'(m_ovf[p]));
            chk($sformatf("p%0d udf", p), 64'(bus.udf_err[p]), 64'(m_udf[p]));
        end
        chk("peak", 64'(bus.peak_pressure), 64'(m_peak));
    endtask

    task automatic cycle();
        @(negedge fifo_clk);
        bus.valid_in = vin_s;
        bus.ready_in = rdy_s;
        bus.err_clr  = clr_s;
        for (int p = 0; p < NP; p++) bus.data_in[p*DW +: DW] = din_s[p];
        model_step();
        @(posedge fifo_clk);
        #1;
        check_all();
    endtask

    task automatic quiet();
        vin_s = '0;
        rdy_s = '0;
        clr_s = 1'b0;
    endtask

    task automatic idle();
        quiet();
        cycle();
    endtask

    task automatic push1(input int p, input flit_t d);
        quiet();
        vin_s[p] = 1'b1;
        din_s[p] = d;
        cycle();
    endtask

    task automatic pop1(input int p);
        quiet();
        rdy_s[p] = 1'b1;
        cycle();
    endtask

    task automatic drain_all();
        quiet();
        rdy_s = '1;
        for (int i = 0; i < DEPTH; i++) cycle();
        quiet();
        clr_s = 1'b1;
        cycle();
        idle();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " valid_out"},    64'(bus.valid_out), 64'd0);
        chk({tag, " full_out"},     64'(bus.full_out), 64'd0);
        chk({tag, " afull_out"},    64'(bus.afull_out), 64'd0);
        chk({tag, " pressure_out"}, 64'(bus.pressure_out), 64'd0);
        chk({tag, " data_out_lo"},  bus.data_out[63:0], 64'd0);
        chk({tag, " data_out_hi"},  64'(bus.data_out[NP*DW-1:64]), 64'd0);
        chk({tag, " peak"},         64'(bus.peak_pressure), 64'd0);
        chk({tag, " ovf_err"},      64'(bus.ovf_err), 64'd0);
        chk({tag, " udf_err"},      64'(bus.udf_err), 64'd0);
    endtask

    initial begin
        int tgt [NP];
        flit_t exp_h;

        bus.data_in  = '0;
        bus.valid_in = '0;
        bus.ready_in = '0;
        bus.err_clr  = 1'b0;
        quiet();
        for (int p = 0; p < NP; p++) din_s[p] = '0;
        model_reset();

        // Reset state
        #12;
        check_all_zero("reset");
        @(negedge fifo_clk);
        rst_n = 1'b1;

        // 1. Table: push 0x01..0x08 on port 2, then pop all eight
        for (int i = 0; i < 8; i++)
            tbl[i] = '{1'b1, 1'b0, 8'(i + 1), 4'(i + 1), (i + 1) >= 6, (i + 1) == 8, 1'b1, 8'h01};
        for (int i = 0; i < 8; i++)
            tbl[8 + i] = '{1'b0, 1'b1, 8'h00, 4'(7 - i), (7 - i) >= 6, 1'b0, (7 - i) > 0,
                           ((7 - i) > 0) ? 8'(i + 2) : 8'h00};
        for (int i = 0; i < 16; i++) begin
            quiet();
            vin_s[PORT_S] = tbl[i].vin;
            rdy_s[PORT_S] = tbl[i].rdy;
            din_s[PORT_S] = DW'(tbl[i].din);
            cycle();
            chk($sformatf("t1[%0d] pressure", i), 64'(pres(PORT_S)), 64'(tbl[i].cnt));
            chk($sformatf("t1[%0d] afull", i), 64'(bus.afull_out[PORT_S]), 64'(tbl[i].af));
            chk($sformatf("t1[%0d] full", i), 64'(bus.full_out[PORT_S]), 64'(tbl[i].full));
            chk($sformatf("t1[%0d] valid", i), 64'(bus.valid_out[PORT_S]), 64'(tbl[i].valid));
            chk($sformatf("t1[%0d] head", i), 64'(head(PORT_S)), 64'(tbl[i].head));
        end

        // 2. Full port 0 with simultaneous push and pop
        for (int k = 0; k < 8; k++) push1(PORT_N, DW'(40'h200 + k));
        for (int k = 0; k < 3; k++) begin
            quiet();
            vin_s[PORT_N] = 1'b1;
            rdy_s[PORT_N] = 1'b1;
            din_s[PORT_N] = DW'(40'h300 + k);
            cycle();
            chk("t2 pressure", 64'(pres(PORT_N)), 64'd8);
            chk("t2 ovf", 64'(bus.ovf_err[PORT_N]), 64'd0);
        end
        for (int k = 0; k < 8; k++) begin
            exp_h = (k < 5) ? DW'(40'h203 + k) : DW'(40'h300 + k - 5);
            chk($sformatf("t2 head%0d", k), 64'(head(PORT_N)), 64'(exp_h));
            pop1(PORT_N);
        end

        // 3. Overflow on port 1 and err_clr precedence
        for (int k = 0; k < 8; k++) push1(PORT_E, DW'(40'h400 + k));
        push1(PORT_E, DW'(40'hDEAD));
        chk("t3 ovf set", 64'(bus.ovf_err[PORT_E]), 64'd1);
        chk("t3 pressure", 64'(pres(PORT_E)), 64'd8);
        quiet(); clr_s = 1'b1; cycle();
        chk("t3 ovf cleared", 64'(bus.ovf_err[PORT_E]), 64'd0);
        quiet(); clr_s = 1'b1; vin_s[PORT_E] = 1'b1; din_s[PORT_E] = DW'(40'hBEEF); cycle();
        chk("t3 ovf wins clr", 64'(bus.ovf_err[PORT_E]), 64'd1);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("t3 head%0d", k), 64'(head(PORT_E)), 64'(40'h400 + k));
            pop1(PORT_E);
        end
        quiet(); clr_s = 1'b1; cycle();

        // 4. Empty port 4: push and pop together
        quiet();
        vin_s[PORT_L] = 1'b1;
        rdy_s[PORT_L] = 1'b1;
        din_s[PORT_L] = DW'(40'h500);
        cycle();
        chk("t4 udf", 64'(bus.udf_err[PORT_L]), 64'd1);
        chk("t4 pressure", 64'(pres(PORT_L)), 64'd1);
        chk("t4 valid", 64'(bus.valid_out[PORT_L]), 64'd1);
        chk("t4 head", 64'(head(PORT_L)), 64'(40'h500));
        push1(PORT_L, DW'(40'h501));
        pop1(PORT_L);
        chk("t4 head2", 64'(head(PORT_L)), 64'(40'h501));
        pop1(PORT_L);
        drain_all();

        // 5. Peak pressure
        tgt = '{3, 7, 0, 5, 2};
        for (int k = 0; k < 7; k++) begin
            quiet();
            for (int p = 0; p < NP; p++) begin
                vin_s[p] = (k < tgt[p]);
                din_s[p] = DW'({$urandom(), $urandom()});
            end
            cycle();
        end
        idle();
        chk("t5 peak 7", 64'(bus.peak_pressure), 64'd7);
        for (int k = 0; k < 3; k++) pop1(PORT_E);
        idle();
        chk("t5 peak 5", 64'(bus.peak_pressure), 64'd5);

        // 6. Asynchronous reset mid-stream
        @(negedge fifo_clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("t6");
        model_reset();
        @(negedge fifo_clk);
        rst_n = 1'b1;
        quiet();
        vin_s = '1;
        for (int p = 0; p < NP; p++) din_s[p] = DW'(40'h600 + p);
        cycle();
        for (int p = 0; p < NP; p++)
            chk($sformatf("t6 fresh head%0d", p), 64'(head(p)), 64'(40'h600 + p));
        quiet();
        rdy_s = '1;
        cycle();
        idle();

        // Randomized traffic against the queue model
        for (int i = 0; i < 400; i++) begin
            if (i < 200) begin
                vin_s = NP'($urandom() | $urandom());
                rdy_s = NP'($urandom() & $urandom());
            end else begin
                vin_s = NP'($urandom() & $urandom());
                rdy_s = NP'($urandom() | $urandom());
            end
            clr_s = ($urandom_range(0, 15) == 0);
            for (int p = 0; p < NP; p++) din_s[p] = DW'({$urandom(), $urandom()});
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
